tweet_buffer: RTL and testbench
===============================

Name: tweet_buffer

Overview:
- Parametrised successor of the single-channel tweet capture/playback block.
- Receives UART frames on serial_in using a mid-bit sampled receiver with start-bit validation, and stores each byte in an internal buffer of 2**ADDR_W entries.
- On a play request, replays the stored message byte-by-byte to a downstream serial transmitter through a tx_ready/tx_start handshake.
- Adds configurable width, depth and baud, optional echo, explicit clear, fill count, and overflow/framing flags.

Parameters:
DATA_BITS, 8, payload bits per frame (LSB first), 5..8
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W
CLKS_PER_BIT, 5208, sysclk cycles per bit, must be >= 4
ECHO, 0, 1 = each accepted byte is also forwarded to tx while IDLE

Ports:
sysclk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low forces CLEAR
serial_in  in  1  UART line, idle high, asynchronous
play  in  1  single-cycle play request, already debounced
clear  in  1  single-cycle clear request
tx_ready  in  1  downstream transmitter can accept a byte
tx_start  out  1  one-cycle strobe; tx_data valid in the same cycle
tx_data  out  DATA_BITS  byte to transmit
count  out  ADDR_W+1  number of stored bytes, 0..DEPTH
busy  out  1  high in PLAY or CLEAR
overflow  out  1  sticky: a byte was dropped because the buffer was full
frame_err  out  1  sticky: a stop bit was sampled low

Behaviour:
- Reset (reset_n low, asynchronous):
  - tx_start=0, tx_data=0, count=0, busy=0, overflow=0, frame_err=0.
  - Pointers zeroed, FSM in IDLE, receiver in RX_IDLE.
  - Buffer memory is not reset.
- Receiver:
  - serial_in passes through a 2-flop synchroniser before any use.
  - RX_IDLE: a synchronised falling edge loads the bit timer with CLKS_PER_BIT/2 and enters RX_START.
  - RX_START: at timer expiry, sample the line. Low enters RX_DATA. High is a glitch: return to RX_IDLE, no flag set.
  - RX_DATA: sample every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first.
  - RX_STOP: sample once after CLKS_PER_BIT.
    - Line high: byte accepted.
    - Line low: frame_err set, byte discarded, and the receiver waits for the line to return high before re-entering RX_IDLE.
- Byte accepted:
  - If FSM is not CLEAR and count < DEPTH: write the byte at wr_ptr (= count) and increment count, both in the same cycle.
  - If count == DEPTH: drop the byte and set overflow.
  - During CLEAR: drop the byte silently, no flag.
  - ECHO=1, FSM IDLE and tx_ready=1: tx_start pulses one cycle later with tx_data = byte. If tx_ready=0, the echo is skipped; it is not queued.
- Main FSM:
  - IDLE:
    - clear or enable low -> CLEAR.
    - Else play with count > 0 -> PLAY: rd_ptr=0, end=count latched.
    - play with count == 0 is ignored.
  - PLAY:
    - Buffer read latency is 1 cycle.
    - When the read data is valid and tx_ready=1: tx_start=1 for exactly one cycle, tx_data = buffer[rd_ptr], rd_ptr increments.
    - tx_start never asserts on two consecutive cycles; at least one cycle gap, so tx_ready can drop.
    - After rd_ptr reaches the latched end -> IDLE. Contents and count are retained, so play can be repeated.
    - Bytes received during PLAY are appended but are not played this pass.
    - play while in PLAY is ignored.
    - clear or enable low aborts immediately -> CLEAR; tx_start is not asserted in the abort cycle.
  - CLEAR:
    - Writes 0 to addresses 0..DEPTH-1, one per cycle, DEPTH cycles.
    - Then count=0, wr_ptr=0, overflow=0, frame_err=0 -> IDLE.
    - If enable is still low, remain in CLEAR after the sweep, re-sweeping; busy stays high.
- Priorities within a cycle:
  - clear/enable > play.
  - A byte write and the start of PLAY in the same cycle: the write happens and is not included in end (end = old count).
- Outputs:
  - busy = (FSM != IDLE).
  - tx_data holds its last value between strobes.
  - count wrap is impossible; it saturates at DEPTH.

Test Plan:
(Bench uses CLKS_PER_BIT=16, ADDR_W=2.)
- Send frames 0x48, 0x69 at 16 clk/bit, then pulse play with tx_ready=1 -> count=2; two tx_start strobes with tx_data 0x48 then 0x69, non-adjacent; busy low after; count still 2.
- Send 5 frames 0x41..0x45 -> count=4, overflow=1; play emits 0x41..0x44 only.
- Hold serial_in low for 6 clk then release -> no receive, count=0, frame_err=0. Next, send 0x55 with stop bit low -> frame_err=1, count=0.
- During playback of 3 bytes, hold tx_ready=0 for 50 clk after the first strobe -> no strobe while low; the second byte follows within 3 clk of tx_ready rising.
- Pulse clear mid-PLAY -> no further tx_start; busy high for 4 clk; then count=0 and flags 0. Play afterwards is ignored.
- ECHO=1: send 0x7A with tx_ready=1 -> one tx_start with 0x7A, stored, count=1. Deassert reset_n mid-frame -> outputs zero immediately; the subsequent frame is received correctly.

Source files
------------

// File: rtl/tweet_buffer.sv
// UART capture buffer: receives frames into a 2**ADDR_W byte store and replays them
// to a downstream transmitter over a tx_ready/tx_start handshake.
//
//   state | meaning
//   IDLE  | capturing; waiting for play or clear
//   PLAY  | replaying bytes 0..end-1, one strobe per two cycles at most
//   CLEAR | zeroing the store one address per cycle, then resetting count/flags
module tweet_buffer #(
    parameter int DATA_BITS    = 8,
    parameter int ADDR_W       = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int ECHO         = 0
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 serial_in,
    input  logic                 play,
    input  logic                 clear,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    output logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 overflow,
    output logic                 frame_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_BITS);
    localparam logic [TW-1:0]   FULL_T  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]   HALF_T  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]   LAST_B  = BW'(DATA_BITS - 1);
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, PLAY, CLEAR} state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    state_t    state, state_next;
    rx_state_t rx_state;

    logic                 sync1, sync2, line_prev;
    logic [TW-1:0]        rx_timer;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_valid, rx_ferr;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_data;
    logic [ADDR_W:0]      rd_ptr, end_cnt;
    logic                 rd_valid;
    logic [ADDR_W-1:0]    clr_addr;

    logic                 abort, play_go, clr_go, fire, sweep_done;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;

    // Receiver: timer is a down-counter; every expiry is a mid-bit sample point.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_timer  <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            sync1     <= serial_in;
            sync2     <= sync1;
            line_prev <= sync2;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
            if (rx_timer != '0)
                rx_timer <= rx_timer - 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    if (line_prev && !sync2) begin
                        rx_timer <= HALF_T;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_timer == '0) begin
                        if (!sync2) begin
                            rx_timer <= FULL_T;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_timer == '0) begin
                        rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
                        rx_timer <= FULL_T;
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == LAST_B)
                            rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_timer == '0) begin
                        if (sync2) begin
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_ferr  <= 1'b1;
                            rx_state <= RX_WAIT;
                        end
                    end
                end
                RX_WAIT: begin
                    if (sync2)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        abort      = clear || !enable;
        play_go    = 1'b0;
        clr_go     = 1'b0;
        fire       = 1'b0;
        sweep_done = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    state_next = CLEAR;
                    clr_go     = 1'b1;
                end else if (play && count != '0) begin
                    state_next = PLAY;
                    play_go    = 1'b1;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_next = CLEAR;
                    clr_go     = 1'b1;
                end else if (rd_valid && tx_ready) begin
                    fire = 1'b1;
                    if (rd_ptr + 1'b1 == end_cnt)
                        state_next = IDLE;
                end
            end
            CLEAR: begin
                if (clr_addr == '1) begin
                    sweep_done = 1'b1;
                    if (enable)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
        end else if (rx_valid && count != DEPTH_C) begin
            mem_we    = 1'b1;
            mem_addr  = count[ADDR_W-1:0];
            mem_wdata = rx_shift;
        end
    end

    always_ff @(posedge sysclk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end

    // rd_valid toggles low after each strobe, which both covers read latency and forces the gap.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            rd_ptr    <= '0;
            end_cnt   <= '0;
            rd_valid  <= 1'b0;
            clr_addr  <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_start <= 1'b0;
            if (sweep_done) begin
                count     <= '0;
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end
            if (rx_ferr)
                frame_err <= 1'b1;
            if (rx_valid && state != CLEAR) begin
                if (count != DEPTH_C)
                    count <= count + 1'b1;
                else
                    overflow <= 1'b1;
                if (ECHO != 0 && state == IDLE && tx_ready) begin
                    tx_start <= 1'b1;
                    tx_data  <= rx_shift;
                end
            end
            if (play_go) begin
                rd_ptr   <= '0;
                end_cnt  <= count;
                rd_valid <= 1'b0;
            end else if (state == PLAY) begin
                if (fire) begin
                    tx_start <= 1'b1;
                    tx_data  <= rd_data;
                    rd_ptr   <= rd_ptr + 1'b1;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= 1'b1;
                end
            end
            if (clr_go)
                clr_addr <= '0;
            else if (state == CLEAR)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tweet_buffer.sv
// Bench for tweet_buffer: UART frames driven bit by bit, results compared with a
// queue model of the stored message and its flags.
module tb_tweet_buffer;
    localparam int DB    = 8;
    localparam int AW    = 2;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic          sysclk = 0;
    logic          reset_n = 0;
    logic          enable = 1;
    logic          serial_in = 1;
    logic          play = 0;
    logic          clear = 0;
    logic          tx_ready = 1;
    logic          tx_start, tx_start_e;
    logic [DB-1:0] tx_data, tx_data_e;
    logic [AW:0]   count, count_e;
    logic          busy, busy_e, overflow, overflow_e, frame_err, frame_err_e;

    int errors = 0;
    int checks = 0;
    byte unsigned got_q[$];
    byte unsigned echo_q[$];
    int   adj = 0;
    logic prev_start = 0;

    byte unsigned mq[$];
    bit m_ovf = 0;
    bit m_ferr = 0;

    always #5 sysclk = ~sysclk;

    tweet_buffer #(.DATA_BITS(DB), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .ECHO(0)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
        .play(play), .clear(clear), .tx_ready(tx_ready), .tx_start(tx_start),
        .tx_data(tx_data), .count(count), .busy(busy), .overflow(overflow),
        .frame_err(frame_err));

    tweet_buffer #(.DATA_BITS(DB), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .ECHO(1)) dut_e (
        .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
        .play(play), .clear(clear), .tx_ready(tx_ready), .tx_start(tx_start_e),
        .tx_data(tx_data_e), .count(count_e), .busy(busy_e), .overflow(overflow_e),
        .frame_err(frame_err_e));

    always @(posedge sysclk) begin
        #1;
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (prev_start) adj++;
        end
        prev_start = tx_start;
        if (tx_start_e) echo_q.push_back(tx_data_e);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_byte(input byte unsigned b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge sysclk);
        serial_in = 0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < DB; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge sysclk);
        end
        serial_in = stop_bit;
        repeat (CPB) @(negedge sysclk);
        serial_in = 1;
        repeat (2 * CPB) @(negedge sysclk);
    endtask

    task automatic send_byte(input byte unsigned b);
        send_frame(b, 1'b1);
        model_byte(b);
    endtask

    task automatic do_clear();
        @(negedge sysclk); clear = 1;
        @(negedge sysclk); clear = 0;
        for (int i = 0; i < 50 && busy; i++) @(negedge sysclk);
        mq.delete(); m_ovf = 0; m_ferr = 0;
        got_q.delete(); echo_q.delete(); adj = 0;
    endtask

    task automatic play_and_wait(input bit rand_ready);
        int n;
        @(negedge sysclk); play = 1;
        @(negedge sysclk); play = 0;
        n = 0;
        while (busy && n < 4000) begin
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
            @(negedge sysclk);
            n++;
        end
        tx_ready = 1;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL play_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({tx_start, tx_data, count, busy, overflow, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%0b data=%h count=%0d busy=%0b ovf=%0b ferr=%0b, required all 0",
                     tx_start, tx_data, count, busy, overflow, frame_err);
        end
        reset_n = 1;
        repeat (3) @(negedge sysclk);
        checks++;
        if (count !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_release: count=%0d busy=%0b, required 0 0", count, busy);
        end
    endtask

    task automatic test_basic();
        do_clear();
        send_byte(8'h48);
        send_byte(8'h69);
        checks++;
        if (count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL basic_count: got %0d required %0d", count, mq.size());
        end
        for (int pass = 0; pass < 2; pass++) begin
            got_q.delete(); adj = 0;
            play_and_wait(1'b0);
            checks++;
            if (got_q.size() != mq.size()) begin
                errors++;
                $display("FAIL basic_strobes pass %0d: got %0d strobes required %0d", pass, got_q.size(), mq.size());
            end
            for (int i = 0; i < got_q.size() && i < mq.size(); i++) begin
                checks++;
                if (got_q[i] !== mq[i]) begin
                    errors++;
                    $display("FAIL basic_data[%0d]: got %h required %h", i, got_q[i], mq[i]);
                end
            end
            checks++;
            if (adj != 0 || busy !== 0 || count !== 3'(mq.size())) begin
                errors++;
                $display("FAIL basic_after: adjacent=%0d busy=%0b count=%0d, required 0 0 %0d", adj, busy, count, mq.size());
            end
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 5; i++) send_byte(byte'(8'h41 + i));
        checks++;
        if (count !== 3'(mq.size()) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL ovf_flags: count=%0d ovf=%0b, required %0d %0b", count, overflow, mq.size(), m_ovf);
        end
        play_and_wait(1'b0);
        checks++;
        if (got_q.size() != mq.size()) begin
            errors++;
            $display("FAIL ovf_strobes: got %0d required %0d", got_q.size(), mq.size());
        end
        for (int i = 0; i < got_q.size() && i < mq.size(); i++) begin
            checks++;
            if (got_q[i] !== mq[i]) begin
                errors++;
                $display("FAIL ovf_data[%0d]: got %h required %h", i, got_q[i], mq[i]);
            end
        end
    endtask

    task automatic test_glitch_framing();
        do_clear();
        @(negedge sysclk); serial_in = 0;
        repeat (6) @(negedge sysclk);
        serial_in = 1;
        repeat (40 * CPB / 4) @(negedge sysclk);
        checks++;
        if (count !== 0 || frame_err !== 0) begin
            errors++;
            $display("FAIL glitch: count=%0d ferr=%0b, required 0 0", count, frame_err);
        end
        send_frame(8'h55, 1'b0);
        m_ferr = 1;
        checks++;
        if (frame_err !== m_ferr || count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL frame_err: ferr=%0b count=%0d, required %0b %0d", frame_err, count, m_ferr, mq.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_clear();
        for (int i = 0; i < 3; i++) send_byte(byte'($urandom_range(0, 255)));
        tx_ready = 1;
        @(negedge sysclk); play = 1;
        @(negedge sysclk); play = 0;
        n = 0;
        while (got_q.size() < 1 && n < 200) begin @(negedge sysclk); n++; end
        tx_ready = 0;
        repeat (50) @(negedge sysclk);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL bp_hold: strobes=%0d while stalled, required 1", got_q.size());
        end
        tx_ready = 1;
        n = 0;
        while (got_q.size() < 2 && n < 10) begin @(negedge sysclk); n++; end
        checks++;
        if (got_q.size() < 2 || n > 3) begin
            errors++;
            $display("FAIL bp_resume: strobes=%0d after %0d cycles, required 2 within 3", got_q.size(), n);
        end
        n = 0;
        while (busy && n < 500) begin @(negedge sysclk); n++; end
        checks++;
        if (got_q.size() != mq.size() || adj != 0) begin
            errors++;
            $display("FAIL bp_total: strobes=%0d adjacent=%0d, required %0d 0", got_q.size(), adj, mq.size());
        end
        for (int i = 0; i < got_q.size() && i < mq.size(); i++) begin
            checks++;
            if (got_q[i] !== mq[i]) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h required %h", i, got_q[i], mq[i]);
            end
        end
    endtask

    task automatic test_clear_abort();
        int n;
        do_clear();
        for (int i = 0; i < 3; i++) send_byte(byte'($urandom_range(0, 255)));
        @(negedge sysclk); play = 1;
        @(negedge sysclk); play = 0;
        n = 0;
        while (got_q.size() < 1 && n < 200) begin @(negedge sysclk); n++; end
        @(negedge sysclk); clear = 1;
        @(negedge sysclk); clear = 0;
        n = 0;
        while (busy && n < 100) begin n++; @(negedge sysclk); end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL abort_busy: busy for %0d cycles, required %0d", n, DEPTH);
        end
        repeat (20) @(negedge sysclk);
        checks++;
        if (got_q.size() != 1 || count !== 0 || overflow !== 0 || frame_err !== 0) begin
            errors++;
            $display("FAIL abort_state: strobes=%0d count=%0d ovf=%0b ferr=%0b, required 1 0 0 0",
                     got_q.size(), count, overflow, frame_err);
        end
        mq.delete();
        @(negedge sysclk); play = 1;
        @(negedge sysclk); play = 0;
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL empty_play: busy=%0b, required 0", busy);
        end
        repeat (20) @(negedge sysclk);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL empty_play_strobe: strobes=%0d, required 1", got_q.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) send_byte(byte'($urandom_range(0, 255)));
            checks++;
            if (count !== 3'(mq.size()) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_fill it%0d: count=%0d ovf=%0b, required %0d %0b", it, count, overflow, mq.size(), m_ovf);
            end
            play_and_wait(1'b1);
            checks++;
            if (got_q.size() != mq.size() || adj != 0) begin
                errors++;
                $display("FAIL rand_strobes it%0d: strobes=%0d adjacent=%0d, required %0d 0", it, got_q.size(), adj, mq.size());
            end
            for (int i = 0; i < got_q.size() && i < mq.size(); i++) begin
                checks++;
                if (got_q[i] !== mq[i]) begin
                    errors++;
                    $display("FAIL rand_data it%0d[%0d]: got %h required %h", it, i, got_q[i], mq[i]);
                end
            end
        end
    endtask

    task automatic test_echo_reset();
        logic [7:0] partial;
        @(negedge sysclk); reset_n = 0;
        repeat (3) @(negedge sysclk);
        reset_n = 1;
        repeat (3) @(negedge sysclk);
        echo_q.delete();
        tx_ready = 1;
        send_frame(8'h7A, 1'b1);
        checks++;
        if (echo_q.size() != 1 || count_e !== 1) begin
            errors++;
            $display("FAIL echo_once: strobes=%0d count=%0d, required 1 1", echo_q.size(), count_e);
        end else begin
            checks++;
            if (echo_q[0] !== 8'h7A) begin
                errors++;
                $display("FAIL echo_data: got %h required 7a", echo_q[0]);
            end
        end
        tx_ready = 0;
        send_frame(8'h11, 1'b1);
        tx_ready = 1;
        checks++;
        if (echo_q.size() != 1 || count_e !== 2) begin
            errors++;
            $display("FAIL echo_skip: strobes=%0d count=%0d, required 1 2", echo_q.size(), count_e);
        end
        partial = 8'h0F;
        @(negedge sysclk); serial_in = 0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            serial_in = partial[i];
            repeat (CPB) @(negedge sysclk);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({tx_start_e, tx_data_e, count_e, busy_e, overflow_e, frame_err_e} !== '0) begin
            errors++;
            $display("FAIL async_reset: start=%0b data=%h count=%0d busy=%0b ovf=%0b ferr=%0b, required all 0",
                     tx_start_e, tx_data_e, count_e, busy_e, overflow_e, frame_err_e);
        end
        serial_in = 1;
        repeat (5) @(negedge sysclk);
        reset_n = 1;
        repeat (2 * CPB) @(negedge sysclk);
        echo_q.delete();
        send_frame(8'h3C, 1'b1);
        checks++;
        if (count_e !== 1 || echo_q.size() != 1) begin
            errors++;
            $display("FAIL post_reset_rx: count=%0d strobes=%0d, required 1 1", count_e, echo_q.size());
        end else begin
            checks++;
            if (echo_q[0] !== 8'h3C) begin
                errors++;
                $display("FAIL post_reset_data: got %h required 3c", echo_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_glitch_framing();
        test_backpressure();
        test_clear_abort();
        test_random();
        test_echo_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
